mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Parametrised MEM→WB pipeline boundary register with a valid/ready handshake, a 2-entry skid buffer, flush, and write-back data selection.
- Sits between the data-memory stage and the register-file write port.
- Replaces the fixed 64-bit, always-advancing stage register.
- Lets the core stall write-back (e.g. a register-file port conflict) without losing instructions, and squash in-flight instructions on redirect.

Parameters:
- DATA_W, 64, width of ALU result, memory read data and write-back data.
- REG_AW, 3, register-address width; must be ≥1.
- CTRL_W, 5, width of the opcode-flag bundle (NOOP/ADDI/MOVI/LW/SW one-hot by default).
- ZERO_REG, 1, if 1, writes to register 0 are suppressed.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash all held entries
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  opcode flags
- in_wre  in  1  instruction writes the register file
- in_is_load  in  1  select memory data for write-back
- in_alu  in  DATA_W  ALU result
- in_mem  in  DATA_W  memory read data, valid in the same cycle as in_valid
- in_rd  in  REG_AW  destination register
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB consumes the entry this cycle
- out_ctrl  out  CTRL_W  registered flags
- out_wre  out  1  qualified register-file write enable
- out_wdata  out  DATA_W  write-back data
- out_rd  out  REG_AW  destination register
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main entry M (drives the outputs) and skid entry S; each holds {ctrl, wre, wdata, rd} plus a valid bit.
- Data selection at capture: wdata = in_is_load ? in_mem : in_alu. Fields are stored, never recomputed.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
- in_ready = !S.valid. It is a pure register output with no combinational path from out_ready.
- out_valid = M.valid. out_ctrl, out_rd and out_wdata come from M.
- out_wre = M.valid & M.wre & !(ZERO_REG && M.rd==0).
- Next-state rules (evaluated in this order):
  - M empty, or consumed: M ← S if S.valid, else the incoming entry if accepted, else invalid. When M loads from S and an input is also accepted, S ← the incoming entry; otherwise S is cleared.
  - M full and not consumed, with accept: S ← the incoming entry (S was necessarily empty).
  - Otherwise: hold.
- Latency: 1 cycle from accept to out_valid when the pipe is empty. Full throughput (1 entry/cycle) while out_ready=1.
- Ordering: strictly FIFO. An entry in S always leaves after M.
- flush: the next cycle M.valid=0 and S.valid=0, in_ready=1.
  - flush overrides a simultaneous accept; the incoming entry is dropped.
  - A consume in the flush cycle still counts as a completed write; the register file sees out_wre that cycle.
- stall_cnt: +1 each cycle out_valid & !out_ready. Saturates at all-ones. Not cleared by flush; cleared only by rst.
- Reset: out_valid=0, in_ready=1, out_wre=0, out_ctrl=0, out_wdata=0, out_rd=0, stall_cnt=0; S cleared.
  - Reset mid-operation discards both entries.
  - rst overrides flush and every handshake.
- Data fields of an invalid entry are don't-care, except after reset, where they are 0.

Decomposition:
- Shared pipeline package holds:
  - opcode flag index constants (NOOP=0, ADDI=1, MOVI=2, LW=3, SW=4);
  - CTRL_W;
  - a packed struct type wb_entry_t {ctrl, wre, wdata, rd} parametrised by the widths above.
- One sub-module is natural: skid_buf, a generic 2-entry valid/ready buffer over a WIDTH-bit payload with flush. mem_wb_stage wraps it with data selection, write-enable qualification and the stall counter.

Test Plan:
- Reset then stream: out_ready=1; send LW rd=3 mem=0xDEAD alu=0x10, then ADDI rd=5 alu=0x7.
  - Required: next cycle out_wdata=0xDEAD, out_rd=3, out_wre=1; following cycle out_wdata=0x7, rd=5.
- Backpressure: out_ready=0; send 3 entries A, B, C back to back.
  - Required: A in M, B in S; in_ready=0 the cycle after B is accepted; C is held upstream.
  - Raise out_ready: outputs A, B, C in order with no gaps; stall_cnt equals the number of stalled cycles.
- Zero register: in_wre=1, rd=0, ZERO_REG=1 → out_valid=1, out_wre=0. Same with ZERO_REG=0 → out_wre=1.
- Flush with accept: M and S full; assert flush together with in_valid=1.
  - Required: next cycle out_valid=0, in_ready=1; the flushed and incoming entries never appear.
- Saturation and reset: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles → stall_cnt=15.
  - Pulse rst mid-stall → all outputs 0 and in_ready=1 the next cycle.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM->WB boundary: opcode flag indices,
// default widths and the write-back entry layout.
package mem_wb_stage_pkg;

  localparam int unsigned CTRL_W = 5;

  // One-hot opcode flag bit positions within ctrl
  localparam int unsigned NOOP = 0;
  localparam int unsigned ADDI = 1;
  localparam int unsigned MOVI = 2;
  localparam int unsigned LW   = 3;
  localparam int unsigned SW   = 4;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned REG_AW_DEF = 3;

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic                  wre;
    logic [DATA_W_DEF-1:0] wdata;
    logic [REG_AW_DEF-1:0] rd;
  } wb_entry_t;

  function automatic int unsigned entry_width(int unsigned data_w, int unsigned reg_aw,
                                              int unsigned ctrl_w);
    return ctrl_w + 1 + data_w + reg_aw;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Handshake and data bundle between the MEM stage, the MEM/WB register and write-back.
interface mem_wb_stage_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_wre;
  logic              in_is_load;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_mem;
  logic [REG_AW-1:0] in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_wre;
  logic [DATA_W-1:0] out_wdata;
  logic [REG_AW-1:0] out_rd;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output flush, in_valid, in_ctrl, in_wre, in_is_load, in_alu, in_mem, in_rd, out_ready,
    input  in_ready, out_valid, out_ctrl, out_wre, out_wdata, out_rd, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_wre, in_is_load, in_alu, in_mem, in_rd, out_ready,
    output in_ready, out_valid, out_ctrl, out_wre, out_wdata, out_rd, stall_cnt
  );
endinterface

// File: rtl/mem_wb_stage_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready depends only on registered state.
module skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             accept, consume;

  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign accept    = in_valid & ~s_valid_q;
  assign consume   = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (!m_valid_q || consume) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = accept;
        if (accept) s_data_d = in_data;
      end else begin
        m_valid_d = accept;
        if (accept) m_data_d = in_data;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
    // Squash wins over any simultaneous accept; a consume this cycle has already happened
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: write-back data select at capture, skid buffering,
// zero-register write suppression and a saturating stall counter.
module mem_wb_stage #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned CTRL_W   = mem_wb_stage_pkg::CTRL_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = 16
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);
  import mem_wb_stage_pkg::*;

  localparam int unsigned PayW = entry_width(DATA_W, REG_AW, CTRL_W);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              wre;
    logic [DATA_W-1:0] wdata;
    logic [REG_AW-1:0] rd;
  } entry_t;

  entry_t           in_entry, m_entry;
  logic [PayW-1:0]  in_pay, m_pay;
  logic             m_valid;
  logic             zero_hit;
  logic [CNT_W-1:0] stall_cnt_q;

  always_comb begin
    in_entry.ctrl  = bus.in_ctrl;
    in_entry.wre   = bus.in_wre;
    in_entry.wdata = bus.in_is_load ? bus.in_mem : bus.in_alu;
    in_entry.rd    = bus.in_rd;
  end

  assign in_pay  = in_entry;
  assign m_entry = entry_t'(m_pay);

  skid_buf #(
    .WIDTH(PayW)
  ) u_skid_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (in_pay),
    .out_valid(m_valid),
    .out_ready(bus.out_ready),
    .out_data (m_pay)
  );

  assign zero_hit = (ZERO_REG != 0) && (m_entry.rd == '0);

  assign bus.out_valid = m_valid;
  assign bus.out_ctrl  = m_entry.ctrl;
  assign bus.out_wdata = m_entry.wdata;
  assign bus.out_rd    = m_entry.rd;
  assign bus.out_wre   = m_valid & m_entry.wre & ~zero_hit;
  assign bus.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (m_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a default-parameter DUT plus a ZERO_REG=0, CNT_W=4
// twin driven with identical inputs.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.DATA_W(64), .REG_AW(3), .CTRL_W(5), .CNT_W(16)) ifa ();
  mem_wb_stage_if #(.DATA_W(64), .REG_AW(3), .CTRL_W(5), .CNT_W(4))  ifb ();

  assign ifb.flush      = ifa.flush;
  assign ifb.in_valid   = ifa.in_valid;
  assign ifb.in_ctrl    = ifa.in_ctrl;
  assign ifb.in_wre     = ifa.in_wre;
  assign ifb.in_is_load = ifa.in_is_load;
  assign ifb.in_alu     = ifa.in_alu;
  assign ifb.in_mem     = ifa.in_mem;
  assign ifb.in_rd      = ifa.in_rd;
  assign ifb.out_ready  = ifa.out_ready;

  mem_wb_stage #(.DATA_W(64), .REG_AW(3), .CTRL_W(5), .ZERO_REG(1), .CNT_W(16)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  mem_wb_stage #(.DATA_W(64), .REG_AW(3), .CTRL_W(5), .ZERO_REG(0), .CNT_W(4)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] ctrl, input logic wre,
                       input logic ld, input logic [63:0] alu, input logic [63:0] mem,
                       input logic [2:0] rd);
    ifa.in_valid   = v;
    ifa.in_ctrl    = ctrl;
    ifa.in_wre     = wre;
    ifa.in_is_load = ld;
    ifa.in_alu     = alu;
    ifa.in_mem     = mem;
    ifa.in_rd      = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", ifa.out_valid); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", ifa.in_ready); end
    checks++; if (ifa.out_wre !== 1'b0) begin errors++; $display("FAIL reset_out_wre: got %0b want 0", ifa.out_wre); end
    checks++; if (ifa.out_ctrl !== 5'd0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0", ifa.out_ctrl); end
    checks++; if (ifa.out_wdata !== 64'd0) begin errors++; $display("FAIL reset_out_wdata: got %h want 0", ifa.out_wdata); end
    checks++; if (ifa.out_rd !== 3'd0) begin errors++; $display("FAIL reset_out_rd: got %0d want 0", ifa.out_rd); end
    checks++; if (ifa.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", ifa.stall_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    ifa.out_ready = 1'b1;
    drive(1'b1, 5'b01000, 1'b1, 1'b1, 64'h10, 64'hDEAD, 3'd3);
    step();
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL stream_lw_valid: got %0b want 1", ifa.out_valid); end
    checks++; if (ifa.out_wdata !== 64'hDEAD) begin errors++; $display("FAIL stream_lw_wdata: got %h want dead", ifa.out_wdata); end
    checks++; if (ifa.out_rd !== 3'd3) begin errors++; $display("FAIL stream_lw_rd: got %0d want 3", ifa.out_rd); end
    checks++; if (ifa.out_wre !== 1'b1) begin errors++; $display("FAIL stream_lw_wre: got %0b want 1", ifa.out_wre); end
    checks++; if (ifa.out_ctrl !== 5'b01000) begin errors++; $display("FAIL stream_lw_ctrl: got %b want 01000", ifa.out_ctrl); end
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'h7, 64'h99, 3'd5);
    step();
    checks++; if (ifa.out_wdata !== 64'h7) begin errors++; $display("FAIL stream_addi_wdata: got %h want 7", ifa.out_wdata); end
    checks++; if (ifa.out_rd !== 3'd5) begin errors++; $display("FAIL stream_addi_rd: got %0d want 5", ifa.out_rd); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %0b want 1", ifa.in_ready); end
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0);
    step();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %0b want 0", ifa.out_valid); end
  endtask

  task automatic test_backpressure();
    ifa.out_ready = 1'b0;
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'hA1, 64'h0, 3'd1);
    step();
    checks++; if (ifa.out_wdata !== 64'hA1) begin errors++; $display("FAIL bp_a_in_m: got %h want a1", ifa.out_wdata); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a: got %0b want 1", ifa.in_ready); end
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'hB2, 64'h0, 3'd2);
    step();
    checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b: got %0b want 0", ifa.in_ready); end
    checks++; if (ifa.out_wdata !== 64'hA1) begin errors++; $display("FAIL bp_a_held: got %h want a1", ifa.out_wdata); end
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'hC3, 64'h0, 3'd4);
    step();
    checks++; if (ifa.out_wdata !== 64'hA1) begin errors++; $display("FAIL bp_a_still: got %h want a1", ifa.out_wdata); end
    checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_held_up: got %0b want 0", ifa.in_ready); end
    ifa.out_ready = 1'b1;
    step();
    checks++; if (ifa.out_valid !== 1'b1 || ifa.out_wdata !== 64'hB2) begin errors++; $display("FAIL bp_out_b: got v=%0b %h want v=1 b2", ifa.out_valid, ifa.out_wdata); end
    checks++; if (ifa.out_rd !== 3'd2) begin errors++; $display("FAIL bp_out_b_rd: got %0d want 2", ifa.out_rd); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_freed: got %0b want 1", ifa.in_ready); end
    step();
    checks++; if (ifa.out_valid !== 1'b1 || ifa.out_wdata !== 64'hC3) begin errors++; $display("FAIL bp_out_c: got v=%0b %h want v=1 c3", ifa.out_valid, ifa.out_wdata); end
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0);
    step();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", ifa.out_valid); end
    checks++; if (ifa.stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 2", ifa.stall_cnt); end
  endtask

  task automatic test_zero_reg();
    ifa.out_ready = 1'b1;
    drive(1'b1, 5'b00100, 1'b1, 1'b0, 64'h55, 64'h0, 3'd0);
    step();
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL zr_valid: got %0b want 1", ifa.out_valid); end
    checks++; if (ifa.out_wre !== 1'b0) begin errors++; $display("FAIL zr_suppressed: got %0b want 0", ifa.out_wre); end
    checks++; if (ifb.out_wre !== 1'b1) begin errors++; $display("FAIL zr_disabled_wre: got %0b want 1", ifb.out_wre); end
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0);
    step();
  endtask

  task automatic test_flush();
    // M and S both full, flush with in_valid high
    ifa.out_ready = 1'b0;
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'h111, 64'h0, 3'd1);
    step();
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'h222, 64'h0, 3'd2);
    step();
    checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL fl_full: got in_ready %0b want 0", ifa.in_ready); end
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'h333, 64'h0, 3'd3);
    ifa.flush = 1'b1;
    step();
    ifa.flush = 1'b0;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL fl_full_valid: got %0b want 0", ifa.out_valid); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL fl_full_ready: got %0b want 1", ifa.in_ready); end
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0);
    step();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL fl_full_gone: got %0b want 0", ifa.out_valid); end
    // Only M full: flush must also drop an entry that would otherwise be accepted
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'h444, 64'h0, 3'd4);
    step();
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'h555, 64'h0, 3'd5);
    ifa.flush = 1'b1;
    step();
    ifa.flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0);
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL fl_accept_dropped: got %0b want 0", ifa.out_valid); end
    step();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL fl_accept_gone: got %0b want 0", ifa.out_valid); end
    checks++; if (ifa.stall_cnt !== 16'd5) begin errors++; $display("FAIL fl_stall_kept: got %0d want 5", ifa.stall_cnt); end
    // Consume in the flush cycle still presents the write
    ifa.out_ready = 1'b1;
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'h666, 64'h0, 3'd6);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0);
    ifa.flush = 1'b1;
    #1;
    checks++; if (ifa.out_wre !== 1'b1) begin errors++; $display("FAIL fl_consume_wre: got %0b want 1", ifa.out_wre); end
    step();
    ifa.flush = 1'b0;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL fl_consume_empty: got %0b want 0", ifa.out_valid); end
  endtask

  task automatic test_saturation_reset();
    ifa.out_ready = 1'b0;
    drive(1'b1, 5'b00010, 1'b1, 1'b0, 64'h777, 64'h0, 3'd7);
    step();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0);
    for (int i = 0; i < 20; i++) step();
    checks++; if (ifb.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d want 15", ifb.stall_cnt); end
    checks++; if (ifa.stall_cnt !== 16'd25) begin errors++; $display("FAIL sat_cnt16: got %0d want 25", ifa.stall_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ifa.out_valid !== 1'b0 || ifa.out_wre !== 1'b0) begin errors++; $display("FAIL rst_mid_outs: got v=%0b wre=%0b want 0 0", ifa.out_valid, ifa.out_wre); end
    checks++; if (ifa.out_wdata !== 64'd0 || ifa.out_rd !== 3'd0 || ifa.out_ctrl !== 5'd0) begin errors++; $display("FAIL rst_mid_data: got %h rd=%0d ctrl=%b want 0", ifa.out_wdata, ifa.out_rd, ifa.out_ctrl); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %0b want 1", ifa.in_ready); end
    checks++; if (ifb.stall_cnt !== 4'd0 || ifa.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0", ifa.stall_cnt, ifb.stall_cnt); end
    step();
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_discard: got %0b want 0", ifa.out_valid); end
  endtask

  initial begin
    ifa.flush     = 1'b0;
    ifa.out_ready = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 3'd0);
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_reg();
    test_flush();
    test_saturation_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
